// File: rtl/first_stage_quadrant_sequencer.sv
// Walks the generator through the selected input quadrants in ascending order:
// clear, run for a fixed beat count, drain, then pulse done for the pass.
module first_stage_quadrant_sequencer #(
   parameter int unsigned BEATS_PER_QUAD = 144,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [3:0]           quad_mask,
   input  logic                 abort,
   input  logic                 stall,
   input  logic                 addr_ready,
   output logic                 quad_en,
   output logic                 quad_clear,
   output logic [1:0]           quadrant,
   output logic                 busy,
   output logic                 quadrant_done,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] beat_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [CNT_WIDTH-1:0] BEAT_LAST  = CNT_WIDTH'(BEATS_PER_QUAD - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYCLES - 1);

   state_t               state_q, state_d;
   logic [3:0]           mask_q, mask_d;
   logic [1:0]           quadrant_q, quadrant_d;
   logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
   logic [CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
   logic                 quad_clear_q, quad_clear_d;
   logic                 busy_q, busy_d;
   logic                 quadrant_done_q, quadrant_done_d;
   logic                 done_q, done_d;

   logic [1:0]           first_quad;
   logic [1:0]           next_quad;
   logic                 has_next;
   logic                 beat;

   // Scan from the top down so the last hit is the lowest qualifying index.
   always_comb begin
      logic [1:0] idx;
      idx        = '0;
      first_quad = '0;
      next_quad  = '0;
      has_next   = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = 2'(3 - i);
         if (quad_mask[idx]) begin
            first_quad = idx;
         end
         if (mask_q[idx] && (idx > quadrant_q)) begin
            next_quad = idx;
            has_next  = 1'b1;
         end
      end
   end

   assign quad_en = (state_q == S_RUN) && !stall;
   assign beat    = quad_en && addr_ready;

   always_comb begin
      state_d         = state_q;
      mask_d          = mask_q;
      quadrant_d      = quadrant_q;
      beat_count_d    = beat_count_q;
      drain_cnt_d     = drain_cnt_q;
      quad_clear_d    = 1'b0;
      quadrant_done_d = 1'b0;
      done_d          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d = quad_mask;
               if (quad_mask != 4'b0000) begin
                  quadrant_d   = first_quad;
                  beat_count_d = '0;
                  quad_clear_d = 1'b1;
                  state_d      = S_CLR;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end
            end
         end
         S_CLR: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (beat) begin
               beat_count_d = beat_count_q + CNT_WIDTH'(1);
               if (beat_count_q == BEAT_LAST) begin
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + CNT_WIDTH'(1);
            if (drain_cnt_q == DRAIN_LAST) begin
               quadrant_done_d = 1'b1;
               if (has_next) begin
                  quadrant_d   = next_quad;
                  beat_count_d = '0;
                  quad_clear_d = 1'b1;
                  state_d      = S_CLR;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides every transition above, including a pending quadrant_done.
      if (abort && (state_q == S_CLR || state_q == S_RUN || state_q == S_DRAIN)) begin
         state_d         = S_IDLE;
         quadrant_d      = quadrant_q;
         beat_count_d    = '0;
         drain_cnt_d     = '0;
         quad_clear_d    = 1'b1;
         quadrant_done_d = 1'b0;
         done_d          = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q         <= S_IDLE;
         mask_q          <= '0;
         quadrant_q      <= '0;
         beat_count_q    <= '0;
         drain_cnt_q     <= '0;
         quad_clear_q    <= 1'b0;
         busy_q          <= 1'b0;
         quadrant_done_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         mask_q          <= mask_d;
         quadrant_q      <= quadrant_d;
         beat_count_q    <= beat_count_d;
         drain_cnt_q     <= drain_cnt_d;
         quad_clear_q    <= quad_clear_d;
         busy_q          <= busy_d;
         quadrant_done_q <= quadrant_done_d;
         done_q          <= done_d;
      end
   end

   assign quad_clear    = quad_clear_q;
   assign quadrant      = quadrant_q;
   assign busy          = busy_q;
   assign quadrant_done = quadrant_done_q;
   assign done          = done_q;
   assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_first_stage_quadrant_sequencer.sv
// Directed bench for first_stage_quadrant_sequencer with default parameters
// (144 beats, 4 drain cycles); cycle k = k-th rising edge after the start edge.
module tb_first_stage_quadrant_sequencer;

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic [3:0] quad_mask = 4'b0000;
   logic       abort = 1'b0;
   logic       stall = 1'b0;
   logic       addr_ready = 1'b0;
   logic       quad_en;
   logic       quad_clear;
   logic [1:0] quadrant;
   logic       busy;
   logic       quadrant_done;
   logic       done;
   logic [7:0] beat_count;

   first_stage_quadrant_sequencer #(
      .BEATS_PER_QUAD(144),
      .DRAIN_CYCLES  (4),
      .CNT_WIDTH     (8)
   ) dut (
      .clock        (clock),
      .clear        (clear),
      .start        (start),
      .quad_mask    (quad_mask),
      .abort        (abort),
      .stall        (stall),
      .addr_ready   (addr_ready),
      .quad_en      (quad_en),
      .quad_clear   (quad_clear),
      .quadrant     (quadrant),
      .busy         (busy),
      .quadrant_done(quadrant_done),
      .done         (done),
      .beat_count   (beat_count)
   );

   always #5 clock = ~clock;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int en_cnt [4];
   int clr_cnt, qdone_cnt, done_cnt, done_k, done_with_qdone, en_while_stall;
   int first_quadrant, beat_stall_first, beat_stall_last, beat_at_event, quad_at_event;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      start = 1'b0;
      abort = 1'b0;
      clear = 1'b0;
      stall = 1'b0;
      #1;
   endtask

   // Starts a pass and observes cycles 1..max_k; stops at done unless an abort/clear event is scheduled.
   task automatic run_pass(input logic [3:0] mask, input int stall_from, input int stall_len,
                           input int abort_at, input int clear_at, input int max_k);
      for (int q = 0; q < 4; q++) en_cnt[q] = 0;
      clr_cnt = 0; qdone_cnt = 0; done_cnt = 0; done_k = 0; done_with_qdone = 0;
      en_while_stall = 0; first_quadrant = -1; beat_stall_first = -1; beat_stall_last = -1;
      beat_at_event = -1; quad_at_event = -1;
      quad_mask = mask;
      start = 1'b1;
      for (int k = 1; k <= max_k; k++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         abort = 1'b0;
         clear = 1'b0;
         stall = (k >= stall_from) && (k < stall_from + stall_len);
         if (k == abort_at) abort = 1'b1;
         if (k == clear_at) begin
            clear = 1'b1;
            start = 1'b1;
         end
         #1;
         if (k == 1) first_quadrant = int'(quadrant);
         if (quad_en) en_cnt[quadrant]++;
         if (quad_en && stall) en_while_stall++;
         if (quad_clear) clr_cnt++;
         if (quadrant_done) qdone_cnt++;
         if (done) begin
            done_cnt++;
            done_k = k;
            done_with_qdone = int'(quadrant_done);
         end
         if (k == stall_from) beat_stall_first = int'(beat_count);
         if (k == stall_from + stall_len - 1) beat_stall_last = int'(beat_count);
         if (k == abort_at || k == clear_at) begin
            beat_at_event = int'(beat_count);
            quad_at_event = int'(quadrant);
         end
         if (done && abort_at == 0 && clear_at == 0) break;
      end
   endtask

   initial begin
      addr_ready = 1'b1;
      clear = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_quad_en", quad_en, 1'b0);
      chk("reset_quad_clear", quad_clear, 1'b0);
      chk("reset_quadrant", quadrant, 2'd0);
      chk("reset_beat_count", beat_count, 8'd0);
      chk("reset_pulses", {quadrant_done, done}, 2'b00);
      step();

      // Single quadrant 0, no stall.
      run_pass(4'b0001, 0, 0, 0, 0, 400);
      chk("q0_clear_pulses", clr_cnt, 1);
      chk("q0_en_cycles", en_cnt[0], 144);
      chk("q0_done_cycle", done_k, 150);
      chk("q0_qdone_count", qdone_cnt, 1);
      chk("q0_done_with_qdone", done_with_qdone, 1);
      chk("q0_beat_count_final", beat_count, 8'd144);
      step();
      chk("q0_idle_busy", busy, 1'b0);
      chk("q0_idle_done", done, 1'b0);

      // Quadrants 1 and 3.
      run_pass(4'b1010, 0, 0, 0, 0, 700);
      chk("m1010_first_quadrant", first_quadrant, 1);
      chk("m1010_en_q0", en_cnt[0], 0);
      chk("m1010_en_q1", en_cnt[1], 144);
      chk("m1010_en_q2", en_cnt[2], 0);
      chk("m1010_en_q3", en_cnt[3], 144);
      chk("m1010_clear_pulses", clr_cnt, 2);
      chk("m1010_qdone_count", qdone_cnt, 2);
      chk("m1010_done_cycle", done_k, 299);
      chk("m1010_done_with_qdone", done_with_qdone, 1);
      chk("m1010_final_quadrant", quadrant, 2'd3);
      step();

      // Ten stall cycles in the middle of the quadrant.
      run_pass(4'b0001, 50, 10, 0, 0, 400);
      chk("stall_en_while_stalled", en_while_stall, 0);
      chk("stall_beat_at_start", beat_stall_first, 48);
      chk("stall_beat_at_end", beat_stall_last, 48);
      chk("stall_en_cycles", en_cnt[0], 144);
      chk("stall_done_cycle", done_k, 160);
      step();

      // Empty mask: immediate FIN.
      run_pass(4'b0000, 0, 0, 0, 0, 20);
      chk("empty_done_cycle", done_k, 1);
      chk("empty_en_cycles", en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3], 0);
      chk("empty_clear_pulses", clr_cnt, 0);
      step();
      chk("empty_idle_busy", busy, 1'b0);

      // Abort at beat 50 of quadrant 2.
      run_pass(4'b1111, 0, 0, 350, 0, 350);
      chk("abort_quad_at_event", quad_at_event, 2);
      chk("abort_beat_at_event", beat_at_event, 50);
      chk("abort_qdone_before", qdone_cnt, 2);
      chk("abort_no_done_before", done_cnt, 0);
      step();
      chk("abort_busy", busy, 1'b0);
      chk("abort_quad_clear", quad_clear, 1'b1);
      chk("abort_beat_count", beat_count, 8'd0);
      chk("abort_pulses", {quadrant_done, done}, 2'b00);
      step();
      chk("abort_quad_clear_single", quad_clear, 1'b0);
      chk("abort_still_idle", busy, 1'b0);

      // Restart after abort begins at quadrant 0.
      run_pass(4'b0001, 0, 0, 0, 0, 400);
      chk("restart_first_quadrant", first_quadrant, 0);
      chk("restart_en_cycles", en_cnt[0], 144);
      chk("restart_done_cycle", done_k, 150);
      step();

      // Reset with start during DRAIN of quadrant 1.
      run_pass(4'b0010, 0, 0, 0, 147, 147);
      chk("clr_in_drain_beat", beat_at_event, 144);
      chk("clr_in_drain_busy_before", busy, 1'b1);
      step();
      chk("clr_busy", busy, 1'b0);
      chk("clr_quadrant", quadrant, 2'd0);
      chk("clr_beat_count", beat_count, 8'd0);
      chk("clr_quad_clear", quad_clear, 1'b0);
      chk("clr_quad_en", quad_en, 1'b0);
      chk("clr_pulses", {quadrant_done, done}, 2'b00);
      begin
         int pulses;
         pulses = 0;
         for (int k = 0; k < 8; k++) begin
            step();
            if (busy || quadrant_done || done || quad_clear || quad_en) pulses++;
         end
         chk("clr_quiet_after", pulses, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
